sum_1to10_with_regfile_control_unit: RTL
========================================

Name: sum_1to10_with_regfile_control_unit

Overview:
- Moore FSM that sequences the 4-entry register-file datapath to compute 1+2+…+10 and load the result into the datapath's output register.
- Sits directly upstream of the datapath. Drives its read/write addresses, write enable, adder-B source select (1 = constant 1, 0 = read port 1) and output-register load. Consumes its iLe10 comparator flag (adder-B operand <= 10).
- Register map: $0 = hard zero, $1 = i, $2 = sum, $3 unused. Adds a start/busy/done handshake, abort, iteration counter and watchdog.

Parameters:
MAX_ITER, 16, number of completed loop iterations after which a still-true iLe10 is treated as a datapath fault (1..255).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  return to IDLE; sampled in any non-IDLE state
iLe10  in  1  datapath comparator result (valid combinationally in CMP)
R1SrcSel  out  1  adder B source: 1 = constant 1, 0 = r_data_1
r_addr_0  out  2  regfile read address, port 0 (adder A / out reg source)
r_addr_1  out  2  regfile read address, port 1
w_en  out  1  regfile write enable
w_addr  out  2  regfile write address
OutLoad  out  1  datapath output register load
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
error  out  1  sticky watchdog fault flag
iter_cnt  out  8  number of ADD_SUM cycles executed in the current/last run

Behaviour:
- Reset (async): state = IDLE, iter_cnt = 0, error = 0. All control outputs are 0; busy = 0; done = 0.
- Control outputs are pure Moore decode of state. Any field not listed for a state is 0.
- States and outputs:
  IDLE: all 0. If start=1, go to INIT_I; clear iter_cnt and error.
  INIT_I: r_addr_0=0, R1SrcSel=1, w_addr=1, w_en=1. Effect: $1 <= 1. Next: INIT_SUM.
  INIT_SUM: r_addr_0=0, r_addr_1=0, R1SrcSel=0, w_addr=2, w_en=1. Effect: $2 <= 0. Next: CMP.
  CMP: r_addr_1=1, R1SrcSel=0; no write.
    - iLe10=0: go to OUTPUT.
    - iLe10=1 and iter_cnt == MAX_ITER: go to ERROR.
    - otherwise: go to ADD_SUM.
  ADD_SUM: r_addr_0=2, r_addr_1=1, R1SrcSel=0, w_addr=2, w_en=1. Effect: $2 <= $2+$1. iter_cnt +1 (saturates at 255). Next: INC_I.
  INC_I: r_addr_0=1, R1SrcSel=1, w_addr=1, w_en=1. Effect: $1 <= $1+1. Next: CMP.
  OUTPUT: r_addr_0=2, OutLoad=1. Next: DONE.
  DONE: done=1, busy=1. Next: IDLE (start ignored in this cycle).
  ERROR: error set to 1 on entry; all other outputs 0, busy=1. Next: IDLE. error stays high until the next accepted start or rst.
- Timing with a correct datapath:
  - Start accepted at edge 0 gives INIT_I in cycle 1 and INIT_SUM in cycle 2.
  - Cycles 3–32 are 10 × (CMP, ADD_SUM, INC_I); cycle 33 is the exiting CMP; cycle 34 is OUTPUT; cycle 35 is DONE.
  - Datapath out = 55 from cycle 35 onward. iter_cnt = 10 at done.
- start while busy is ignored: no restart, no queuing.
- abort=1 in any non-IDLE state:
  - w_en and OutLoad are forced to 0 combinationally in that cycle.
  - Next state is IDLE; done is not pulsed; iter_cnt is held.
  - abort has priority over all other transitions, including CMP decisions. abort in IDLE has no effect.
- Register-file writes to $0 never occur from this block (w_addr is never 0 when w_en=1).
- Async rst mid-run returns to IDLE immediately with all outputs 0.

Test Plan:
- rst, then start pulse with reference datapath attached -> busy rises next cycle; done pulses exactly 35 cycles after the start edge; out=55; iter_cnt=10; error=0.
- Check per-state outputs during the run -> INIT_I drives w_addr=1, R1SrcSel=1, w_en=1; ADD_SUM drives r_addr_0=2, r_addr_1=1, w_addr=2; OutLoad is high only in cycle 34.
- Hold iLe10=1 permanently (fault model), MAX_ITER=16 -> ERROR entered after 16th ADD_SUM; error=1, done never pulses, busy drops one cycle later; next start clears error.
- abort asserted in cycle 10 -> w_en=0 that cycle, IDLE next cycle, done=0; a new start then completes normally with out=55.
- start pulses while busy and during DONE -> ignored; exactly one done pulse per accepted start.
- rst asserted asynchronously mid-loop -> state IDLE, all outputs 0, iter_cnt=0, error=0 without waiting for a clock edge.

Source files
------------

// File: rtl/sum_1to10_with_regfile_control_unit.sv
// Moore sequencer driving the 4-entry regfile datapath to compute 1+..+10.
// It adds a start/busy/done handshake, an abort, an iteration counter and a watchdog.
module sum_1to10_with_regfile_control_unit #(
  parameter int unsigned MAX_ITER = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       iLe10,
  output logic       R1SrcSel,
  output logic [1:0] r_addr_0,
  output logic [1:0] r_addr_1,
  output logic       w_en,
  output logic [1:0] w_addr,
  output logic       OutLoad,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] iter_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_I,
    S_INIT_SUM,
    S_CMP,
    S_ADD_SUM,
    S_INC_I,
    S_OUTPUT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_iter_cnt;
  logic       r_error;
  logic       w_en_dec;
  logic       w_outload_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_iter_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_iter_cnt <= '0;
        r_error    <= 1'b0;
      end else if (r_state == S_ADD_SUM && !abort && r_iter_cnt != 8'hFF) begin
        r_iter_cnt <= r_iter_cnt + 8'd1;
      end
      if (w_state_nxt == S_ERROR && r_state != S_ERROR) begin
        r_error <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    R1SrcSel      = 1'b0;
    r_addr_0      = 2'd0;
    r_addr_1      = 2'd0;
    w_en_dec      = 1'b0;
    w_addr        = 2'd0;
    w_outload_dec = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_INIT_I;
      end
      S_INIT_I: begin
        R1SrcSel    = 1'b1;
        w_addr      = 2'd1;
        w_en_dec    = 1'b1;
        w_state_nxt = S_INIT_SUM;
      end
      S_INIT_SUM: begin
        w_addr      = 2'd2;
        w_en_dec    = 1'b1;
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        r_addr_1 = 2'd1;
        if (!iLe10)                           w_state_nxt = S_OUTPUT;
        else if (r_iter_cnt == 8'(MAX_ITER)) w_state_nxt = S_ERROR;
        else                                  w_state_nxt = S_ADD_SUM;
      end
      S_ADD_SUM: begin
        r_addr_0    = 2'd2;
        r_addr_1    = 2'd1;
        w_addr      = 2'd2;
        w_en_dec    = 1'b1;
        w_state_nxt = S_INC_I;
      end
      S_INC_I: begin
        r_addr_0    = 2'd1;
        R1SrcSel    = 1'b1;
        w_addr      = 2'd1;
        w_en_dec    = 1'b1;
        w_state_nxt = S_CMP;
      end
      S_OUTPUT: begin
        r_addr_0      = 2'd2;
        w_outload_dec = 1'b1;
        w_state_nxt   = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
    // abort overrides every decision, including the CMP branch; it is inert in IDLE
    if (abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  assign w_en     = w_en_dec & ~abort;
  assign OutLoad  = w_outload_dec & ~abort;
  assign error    = r_error;
  assign iter_cnt = r_iter_cnt;

endmodule
